// File: rtl/dram_arbiter_if.sv
// Core-side request/grant/return signals and DRAM command signals of dram_arbiter.
// The slave modport is the arbiter's view; master is the cores-plus-DRAM view.
interface dram_arbiter_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8
) ();

  logic [NUM_CORES-1:0]        i_req;
  logic [NUM_CORES-1:0]        i_we;
  logic [NUM_CORES*ADDR_W-1:0] i_addr;
  logic [NUM_CORES*DATA_W-1:0] i_wdata;
  logic [NUM_CORES-1:0]        o_gnt;
  logic [NUM_CORES-1:0]        o_rvalid;
  logic [DATA_W-1:0]           o_rdata;
  logic [ADDR_W-1:0]           o_mem_addr;
  logic [DATA_W-1:0]           o_mem_wdata;
  logic                        o_mem_we;
  logic                        o_mem_re;
  logic [DATA_W-1:0]           i_mem_rdata;
  logic                        o_busy;

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_mem_rdata,
    output o_gnt, o_rvalid, o_rdata, o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re, o_busy
  );

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_mem_rdata,
    input  o_gnt, o_rvalid, o_rdata, o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re, o_busy
  );

endinterface

// File: rtl/dram_arbiter.sv
// Multi-core DRAM arbiter: one registered command per cycle (round-robin or fixed priority)
// with a tag shift pipeline that routes each read return back to its requesting core.
module dram_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned ARB_MODE  = 0
) (
  input logic          i_clk,
  input logic          i_rst_n,
  dram_arbiter_if.slave io_bus
);

  localparam int unsigned IdW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  typedef logic [IdW-1:0] id_t;
  localparam id_t LastId = id_t'(NUM_CORES - 1);

  logic [NUM_CORES-1:0] w_elig;
  logic                 w_found;
  logic                 w_is_read;
  id_t                  w_start;
  id_t                  w_win;

  logic [NUM_CORES-1:0] r_gnt;
  logic [NUM_CORES-1:0] r_rvalid;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_mem_wdata;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_mem_we;
  logic                 r_mem_re;
  id_t                  r_last;
  logic [RD_LAT:0]      r_tag_v;
  id_t                  r_tag_id [RD_LAT+1];

  // First eligible core at or after 'start', wrapping past the top index.
  function automatic id_t f_pick(input logic [NUM_CORES-1:0] elig, input id_t start);
    id_t         win;
    logic        found;
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      idx = 32'(start) + i;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!found && elig[id_t'(idx)]) begin
        found = 1'b1;
        win   = id_t'(idx);
      end
    end
    return win;
  endfunction

  // A core holding o_gnt this cycle sits out one arbitration round.
  assign w_elig    = io_bus.i_req & ~r_gnt;
  assign w_found   = |w_elig;
  assign w_start   = (ARB_MODE == 1) ? '0 : ((r_last == LastId) ? '0 : r_last + 1'b1);
  assign w_win     = f_pick(w_elig, w_start);
  assign w_is_read = w_found & ~io_bus.i_we[w_win];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_last      <= LastId;
    end else begin
      r_gnt    <= '0;
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      if (w_found) begin
        r_gnt[w_win] <= 1'b1;
        r_mem_addr   <= io_bus.i_addr[w_win * ADDR_W +: ADDR_W];
        r_mem_wdata  <= io_bus.i_wdata[w_win * DATA_W +: DATA_W];
        r_mem_we     <= io_bus.i_we[w_win];
        r_mem_re     <= ~io_bus.i_we[w_win];
        r_last       <= w_win;
      end
    end
  end

  // Stage 0 loads with the command; the last stage lines up with i_mem_rdata arriving.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag_v  <= '0;
      for (int unsigned i = 0; i <= RD_LAT; i++) r_tag_id[i] <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_tag_v[0]  <= w_is_read;
      r_tag_id[0] <= w_win;
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
      r_rvalid <= '0;
      if (r_tag_v[RD_LAT]) begin
        r_rvalid[r_tag_id[RD_LAT]] <= 1'b1;
        r_rdata                    <= io_bus.i_mem_rdata;
      end
    end
  end

  assign io_bus.o_gnt       = r_gnt;
  assign io_bus.o_rvalid    = r_rvalid;
  assign io_bus.o_rdata     = r_rdata;
  assign io_bus.o_mem_addr  = r_mem_addr;
  assign io_bus.o_mem_wdata = r_mem_wdata;
  assign io_bus.o_mem_we    = r_mem_we;
  assign io_bus.o_mem_re    = r_mem_re;
  assign io_bus.o_busy      = r_mem_we | r_mem_re | (|r_tag_v);

  a_gnt_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(r_gnt));
  a_rvalid_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(r_rvalid));
  a_we_re_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(r_mem_we && r_mem_re));

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: four instances (RR, fixed priority, RD_LAT=3, 8-core/16-bit)
// checked against a transaction-level reference model and directed expectations.
module tb_dram_arbiter;

  localparam int NC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_c_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ecount   = 0;

  // Stimulus for the two model-checked instances (index 0: round-robin, 1: fixed priority)
  logic [1:0][3:0]  t_req;
  logic [1:0][3:0]  t_we;
  logic [1:0][63:0] t_addr;
  logic [1:0][31:0] t_wdata;
  logic [1:0][7:0]  t_mrdata;

  logic [3:0]   c_req, c_we;
  logic [63:0]  c_addr;
  logic [31:0]  c_wdata;
  logic [7:0]   c_mrdata;
  logic [7:0]   d_req, d_we;
  logic [127:0] d_addr, d_wdata;
  logic [15:0]  d_mrdata;

  typedef struct {
    int d;
    int due;
    int id;
  } rd_t;

  rd_t              mq[$];
  logic [1:0][3:0]  m_gnt, m_rvalid;
  logic [1:0][15:0] m_addr;
  logic [1:0][7:0]  m_wdata, m_rdata;
  logic [1:0]       m_we, m_re, m_busy;
  int               m_last [2];

  logic [1:0][42:0] obs_all, exp_all;
  logic [42:0]      obs_c;
  logic [66:0]      obs_d;

  dram_arbiter_if #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(8))  if_a ();
  dram_arbiter_if #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(8))  if_b ();
  dram_arbiter_if #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(8))  if_c ();
  dram_arbiter_if #(.NUM_CORES(8), .ADDR_W(16), .DATA_W(16)) if_d ();

  dram_arbiter #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(8), .RD_LAT(1), .ARB_MODE(0)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(if_a));
  dram_arbiter #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(8), .RD_LAT(1), .ARB_MODE(1)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(if_b));
  dram_arbiter #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(8), .RD_LAT(3), .ARB_MODE(0)) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_c_n), .io_bus(if_c));
  dram_arbiter #(.NUM_CORES(8), .ADDR_W(16), .DATA_W(16), .RD_LAT(1), .ARB_MODE(0)) u_dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(if_d));

  assign if_a.i_req = t_req[0];
  assign if_a.i_we = t_we[0];
  assign if_a.i_addr = t_addr[0];
  assign if_a.i_wdata = t_wdata[0];
  assign if_a.i_mem_rdata = t_mrdata[0];
  assign if_b.i_req = t_req[1];
  assign if_b.i_we = t_we[1];
  assign if_b.i_addr = t_addr[1];
  assign if_b.i_wdata = t_wdata[1];
  assign if_b.i_mem_rdata = t_mrdata[1];
  assign if_c.i_req = c_req;
  assign if_c.i_we = c_we;
  assign if_c.i_addr = c_addr;
  assign if_c.i_wdata = c_wdata;
  assign if_c.i_mem_rdata = c_mrdata;
  assign if_d.i_req = d_req;
  assign if_d.i_we = d_we;
  assign if_d.i_addr = d_addr;
  assign if_d.i_wdata = d_wdata;
  assign if_d.i_mem_rdata = d_mrdata;

  assign obs_all = {
    {if_b.o_gnt, if_b.o_rvalid, if_b.o_rdata, if_b.o_mem_addr, if_b.o_mem_wdata,
     if_b.o_mem_we, if_b.o_mem_re, if_b.o_busy},
    {if_a.o_gnt, if_a.o_rvalid, if_a.o_rdata, if_a.o_mem_addr, if_a.o_mem_wdata,
     if_a.o_mem_we, if_a.o_mem_re, if_a.o_busy}};
  assign exp_all = {
    {m_gnt[1], m_rvalid[1], m_rdata[1], m_addr[1], m_wdata[1], m_we[1], m_re[1], m_busy[1]},
    {m_gnt[0], m_rvalid[0], m_rdata[0], m_addr[0], m_wdata[0], m_we[0], m_re[0], m_busy[0]}};
  assign obs_c = {if_c.o_gnt, if_c.o_rvalid, if_c.o_rdata, if_c.o_mem_addr, if_c.o_mem_wdata,
                  if_c.o_mem_we, if_c.o_mem_re, if_c.o_busy};
  assign obs_d = {if_d.o_gnt, if_d.o_rvalid, if_d.o_rdata, if_d.o_mem_addr, if_d.o_mem_wdata,
                  if_d.o_mem_we, if_d.o_mem_re, if_d.o_busy};

  task automatic model_reset();
    mq.delete();
    m_gnt = '0;
    m_rvalid = '0;
    m_addr = '0;
    m_wdata = '0;
    m_rdata = '0;
    m_we = '0;
    m_re = '0;
    m_busy = '0;
    m_last[0] = NC - 1;
    m_last[1] = NC - 1;
  endtask

  // One clock edge: a read issued at edge e returns at edge e+2 with the DRAM data then present.
  task automatic model_step();
    rd_t        keep[$];
    logic [3:0] elig;
    int         w;
    int         c;
    ecount++;
    for (int d = 0; d < 2; d++) begin
      m_rvalid[d] = '0;
      foreach (mq[i]) begin
        if (mq[i].d == d && mq[i].due == ecount) begin
          m_rvalid[d][mq[i].id] = 1'b1;
          m_rdata[d] = t_mrdata[d];
        end
      end
      elig = t_req[d] & ~m_gnt[d];
      w = -1;
      for (int k = 1; k <= NC; k++) begin
        c = (d == 0) ? (m_last[d] + k) % NC : k - 1;
        if (w < 0 && elig[c]) w = c;
      end
      m_gnt[d] = '0;
      m_we[d] = 1'b0;
      m_re[d] = 1'b0;
      if (w >= 0) begin
        m_gnt[d][w] = 1'b1;
        m_addr[d] = t_addr[d][w*16 +: 16];
        m_wdata[d] = t_wdata[d][w*8 +: 8];
        m_we[d] = t_we[d][w];
        m_re[d] = !t_we[d][w];
        m_last[d] = w;
        if (!t_we[d][w]) mq.push_back('{d, ecount + 2, w});
      end
    end
    foreach (mq[i]) if (mq[i].due != ecount) keep.push_back(mq[i]);
    mq = keep;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = m_we[d] | m_re[d];
      foreach (mq[i]) if (mq[i].d == d) m_busy[d] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    t_req = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rst_c_n = 1'b0;
    t_req = '1;
    t_we = '0;
    t_addr = {$urandom, $urandom, $urandom, $urandom};
    t_wdata = {$urandom, $urandom};
    t_mrdata = '0;
    c_req = '1;
    c_we = '0;
    c_addr = '0;
    c_wdata = '0;
    c_mrdata = '0;
    d_req = '1;
    d_we = '0;
    d_addr = '0;
    d_wdata = '0;
    d_mrdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_all[d] !== 43'd0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got %h want 0", d, obs_all[d]);
      end
    end
    n_checks++;
    if (obs_c !== 43'd0) begin
      n_fail++;
      $display("FAIL reset_state_c: got %h want 0", obs_c);
    end
    n_checks++;
    if (obs_d !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_state_d: got %h want 0", obs_d);
    end
    c_req = '0;
    d_req = '0;
    t_req[0] = 4'b1010;
    t_req[1] = 4'b1100;
    rst_n = 1'b1;
    rst_c_n = 1'b1;
    model_step();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_all[d] !== exp_all[d]) begin
        n_fail++;
        $display("FAIL first_arb model[%0d]: got %h want %h", d, obs_all[d], exp_all[d]);
      end
    end
    n_checks++;
    if ({if_a.o_gnt, if_b.o_gnt} !== 8'b0010_0100) begin
      n_fail++;
      $display("FAIL first_arb gnt: got %b %b want 0010 0100", if_a.o_gnt, if_b.o_gnt);
    end
    // Asynchronous assertion in the middle of a cycle with reads in flight
    #3;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_all[d] !== 43'd0) begin
        n_fail++;
        $display("FAIL async_reset[%0d]: got %h want 0", d, obs_all[d]);
      end
    end
    model_reset();
    t_req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      model_step();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs_all[d] !== exp_all[d]) begin
          n_fail++;
          $display("FAIL post_reset model[%0d]: got %h want %h", d, obs_all[d], exp_all[d]);
        end
      end
    end
  endtask

  task automatic test_single_read();
    t_mrdata[0] = 8'h5A;
    t_we[0] = '0;
    t_addr[0][32 +: 16] = 16'h0040;
    t_req[0] = 4'b0100;
    for (int e = 0; e < 4; e++) begin
      model_step();
      if (e == 0) t_req[0] = '0;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs_all[d] !== exp_all[d]) begin
          n_fail++;
          $display("FAIL single_read model[%0d] e%0d: got %h want %h", d, e, obs_all[d], exp_all[d]);
        end
      end
      if (e == 0) begin
        n_checks++;
        if ({if_a.o_gnt, if_a.o_mem_re, if_a.o_mem_addr} !== {4'b0100, 1'b1, 16'h0040}) begin
          n_fail++;
          $display("FAIL single_read issue: got %b %b %h want 0100 1 0040",
                   if_a.o_gnt, if_a.o_mem_re, if_a.o_mem_addr);
        end
      end
      if (e == 2) begin
        n_checks++;
        if ({if_a.o_rvalid, if_a.o_rdata} !== {4'b0100, 8'h5A}) begin
          n_fail++;
          $display("FAIL single_read return: got %b %h want 0100 5a", if_a.o_rvalid, if_a.o_rdata);
        end
      end
    end
  endtask

  task automatic test_rr_stream();
    do_reset();
    t_we[0] = '0;
    t_addr[0] = {$urandom, $urandom};
    t_req[0] = '1;
    for (int i = 0; i < 15; i++) begin
      if (i == 12) t_req[0] = '0;
      t_mrdata[0] = 8'($urandom);
      model_step();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs_all[d] !== exp_all[d]) begin
          n_fail++;
          $display("FAIL rr_stream model[%0d] i%0d: got %h want %h", d, i, obs_all[d], exp_all[d]);
        end
      end
      if (i < 12) begin
        n_checks++;
        if ({if_a.o_gnt, if_a.o_mem_re} !== {4'(1 << (i % 4)), 1'b1}) begin
          n_fail++;
          $display("FAIL rr_stream gnt i%0d: got %b re %b want %b re 1",
                   i, if_a.o_gnt, if_a.o_mem_re, 4'(1 << (i % 4)));
        end
      end
      if (i >= 2 && i < 14) begin
        n_checks++;
        if (if_a.o_rvalid !== 4'(1 << ((i - 2) % 4))) begin
          n_fail++;
          $display("FAIL rr_stream rvalid i%0d: got %b want %b",
                   i, if_a.o_rvalid, 4'(1 << ((i - 2) % 4)));
        end
      end
    end
  endtask

  task automatic test_write();
    t_we[0] = 4'b0010;
    t_addr[0][16 +: 16] = 16'h1234;
    t_wdata[0][8 +: 8] = 8'hA5;
    t_req[0] = 4'b0010;
    for (int e = 0; e < 5; e++) begin
      model_step();
      if (e == 0) begin
        t_req[0] = '0;
        t_we[0] = '0;
        n_checks++;
        if ({if_a.o_mem_we, if_a.o_mem_re, if_a.o_mem_addr, if_a.o_mem_wdata} !==
            {1'b1, 1'b0, 16'h1234, 8'hA5}) begin
          n_fail++;
          $display("FAIL write_cmd: got we%b re%b %h %h want we1 re0 1234 a5",
                   if_a.o_mem_we, if_a.o_mem_re, if_a.o_mem_addr, if_a.o_mem_wdata);
        end
      end
      n_checks++;
      if (if_a.o_rvalid !== 4'b0000) begin
        n_fail++;
        $display("FAIL write_no_rvalid e%0d: got %b want 0000", e, if_a.o_rvalid);
      end
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs_all[d] !== exp_all[d]) begin
          n_fail++;
          $display("FAIL write model[%0d] e%0d: got %h want %h", d, e, obs_all[d], exp_all[d]);
        end
      end
    end
  endtask

  task automatic test_fixed_alternate();
    t_we[1] = '0;
    t_addr[1] = {$urandom, $urandom};
    t_req[1] = 4'b1001;
    for (int i = 0; i < 11; i++) begin
      if (i == 8) t_req[1] = '0;
      t_mrdata[1] = 8'($urandom);
      model_step();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs_all[d] !== exp_all[d]) begin
          n_fail++;
          $display("FAIL fixed_alt model[%0d] i%0d: got %h want %h", d, i, obs_all[d], exp_all[d]);
        end
      end
      if (i < 8) begin
        n_checks++;
        if (if_b.o_gnt !== ((i % 2 == 0) ? 4'b0001 : 4'b1000)) begin
          n_fail++;
          $display("FAIL fixed_alt gnt i%0d: got %b want %b", i, if_b.o_gnt,
                   (i % 2 == 0) ? 4'b0001 : 4'b1000);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] g;
    t_req = '0;
    for (int cyc = 0; cyc < 304; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        g = (d == 0) ? if_a.o_gnt : if_b.o_gnt;
        for (int c = 0; c < NC; c++) begin
          // A core keeps its request and fields stable until it sees its grant
          if (g[c] || !t_req[d][c]) begin
            t_req[d][c] = (cyc < 300) && ($urandom_range(0, 99) < 60);
            t_we[d][c] = 1'($urandom);
            t_addr[d][c*16 +: 16] = 16'($urandom);
            t_wdata[d][c*8 +: 8] = 8'($urandom);
          end
          if (cyc >= 300) t_req[d][c] = 1'b0;
        end
        t_mrdata[d] = 8'($urandom);
      end
      model_step();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs_all[d] !== exp_all[d]) begin
          n_fail++;
          $display("FAIL random model[%0d] cyc%0d: got %h want %h", d, cyc, obs_all[d], exp_all[d]);
        end
      end
    end
  endtask

  task automatic test_lat3_read();
    c_mrdata = 8'h3C;
    c_we = '0;
    c_addr[15:0] = 16'h0100;
    c_req = 4'b0001;
    @(posedge clk);
    #1;
    c_req = '0;
    n_checks++;
    if ({if_c.o_gnt, if_c.o_mem_re, if_c.o_mem_addr} !== {4'b0001, 1'b1, 16'h0100}) begin
      n_fail++;
      $display("FAIL lat3_issue: got %b %b %h want 0001 1 0100",
               if_c.o_gnt, if_c.o_mem_re, if_c.o_mem_addr);
    end
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (if_c.o_rvalid !== ((e == 4) ? 4'b0001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL lat3_rvalid e%0d: got %b want %b", e, if_c.o_rvalid,
                 (e == 4) ? 4'b0001 : 4'b0000);
      end
      if (e <= 3) begin
        n_checks++;
        if (if_c.o_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL lat3_busy e%0d: got %b want 1", e, if_c.o_busy);
        end
      end
      if (e == 4) begin
        n_checks++;
        if (if_c.o_rdata !== 8'h3C) begin
          n_fail++;
          $display("FAIL lat3_rdata: got %h want 3c", if_c.o_rdata);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    c_req = 4'b0001;
    @(posedge clk);
    #1;
    c_req = '0;
    n_checks++;
    if (if_c.o_gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL inflight_gnt: got %b want 0001", if_c.o_gnt);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (if_c.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight_busy: got %b want 1", if_c.o_busy);
    end
    @(posedge clk);
    #1;
    rst_c_n = 1'b0;
    #1;
    n_checks++;
    if ({if_c.o_busy, if_c.o_rvalid, if_c.o_mem_re, if_c.o_gnt} !== 10'd0) begin
      n_fail++;
      $display("FAIL inflight_reset: got busy%b rv%b re%b g%b want all 0",
               if_c.o_busy, if_c.o_rvalid, if_c.o_mem_re, if_c.o_gnt);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (if_c.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_busy_in_reset: got %b want 0", if_c.o_busy);
    end
    rst_c_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (if_c.o_rvalid !== 4'b0000) begin
        n_fail++;
        $display("FAIL inflight_no_return e%0d: got %b want 0000", e, if_c.o_rvalid);
      end
    end
  endtask

  task automatic test_wide_single_core();
    d_mrdata = 16'hBEEF;
    d_we = '0;
    d_addr[127:112] = 16'h7777;
    d_req = 8'h80;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (if_d.o_gnt !== ((e % 2 == 1) ? 8'h80 : 8'h00)) begin
        n_fail++;
        $display("FAIL wide_gnt e%0d: got %h want %h", e, if_d.o_gnt,
                 (e % 2 == 1) ? 8'h80 : 8'h00);
      end
      n_checks++;
      if (if_d.o_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL wide_busy e%0d: got %b want 1", e, if_d.o_busy);
      end
      n_checks++;
      if (if_d.o_rvalid !== ((e >= 3 && e % 2 == 1) ? 8'h80 : 8'h00)) begin
        n_fail++;
        $display("FAIL wide_rvalid e%0d: got %h want %h", e, if_d.o_rvalid,
                 (e >= 3 && e % 2 == 1) ? 8'h80 : 8'h00);
      end
      if (e == 3) begin
        n_checks++;
        if ({if_d.o_rdata, if_d.o_mem_addr} !== {16'hBEEF, 16'h7777}) begin
          n_fail++;
          $display("FAIL wide_data: got %h %h want beef 7777", if_d.o_rdata, if_d.o_mem_addr);
        end
      end
    end
    d_req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_rr_stream();
    test_write();
    test_fixed_alternate();
    test_random();
    test_lat3_read();
    test_reset_inflight();
    test_wide_single_core();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 4: number of requesting cores, legal range 2..16.
REQ-002 Parameter ADDR_W, default 16: DRAM address width.
REQ-003 Parameter DATA_W, default 8: DRAM data width.
REQ-004 Parameter RD_LAT, default 1: DRAM read latency in cycles, legal range 1..4.
REQ-005 Parameter ARB_MODE, default 0: 0 selects round-robin, 1 selects fixed priority with the lowest index winning.
REQ-006 i_clk  in  1  single clock; the block has one clock, and all state changes on its rising edge.
REQ-007 i_rst_n  in  1  asynchronous, active-low reset.
REQ-008 i_req  in  NUM_CORES  per-core access request, held high until granted.
REQ-009 i_we  in  NUM_CORES  per-core write flag: 1 means write, 0 means read.
REQ-010 i_addr  in  NUM_CORES*ADDR_W  per-core address, packed with core 0 in the LSBs.
REQ-011 i_wdata  in  NUM_CORES*DATA_W  per-core write data, packed with core 0 in the LSBs.
REQ-012 o_gnt  out  NUM_CORES  one-hot, one-cycle acceptance pulse.
REQ-013 o_rvalid  out  NUM_CORES  one-hot, one-cycle read-return strobe.
REQ-014 o_rdata  out  DATA_W  read data, broadcast to all cores, qualified by o_rvalid.
REQ-015 o_mem_addr  out  ADDR_W; o_mem_wdata  out  DATA_W; o_mem_we  out  1; o_mem_re  out  1: DRAM command outputs, all registered.
REQ-016 i_mem_rdata  in  DATA_W: DRAM read data, valid RD_LAT cycles after the DRAM samples a read.
REQ-017 o_busy  out  1: high while any command or read return is in flight.

Function
REQ-018 Eligibility per edge:
- a core is eligible when its i_req is high and its o_gnt bit is low;
- a just-granted core therefore cannot be regranted on the next edge.
REQ-019 When at least one core is eligible, the block picks exactly one winner per edge:
- ARB_MODE=0: the first eligible core searching upward, with wrap, from last_winner+1;
- ARB_MODE=1: the lowest eligible index.
REQ-020 On a winning edge the block registers the following, all in the same cycle:
- o_gnt[winner]=1;
- o_mem_addr and o_mem_wdata = the winner's fields;
- o_mem_we = i_we[winner];
- o_mem_re = ~i_we[winner].
REQ-021 When no core is eligible:
- o_gnt, o_mem_we and o_mem_re are 0;
- o_mem_addr and o_mem_wdata hold their last values.
REQ-022 last_winner updates only on winning edges, in both modes.
REQ-023 Read return:
- each read pushes {valid, winner id} into a tag shift pipeline of depth RD_LAT+1;
- when the tag exits, o_rdata <= i_mem_rdata and o_rvalid[id]=1 for one cycle.
REQ-024 Read latency: o_rvalid rises exactly RD_LAT+1 edges after the corresponding o_gnt rises.
REQ-025 Throughput: one command per cycle, with back-to-back reads from different cores fully pipelined.
REQ-026 Return order matches issue order.
REQ-027 A write produces no o_rvalid.
REQ-028 o_rdata holds its value between returns.
REQ-029 The issue and return paths are independent, so a return and a new grant may occur on the same edge.
REQ-030 o_busy = o_mem_we | o_mem_re | (any tag valid).
REQ-031 The block checks no address conflicts: same-address accesses execute in grant order.

Reset
REQ-032 While i_rst_n=0, immediately and asynchronously:
- o_gnt, o_rvalid, o_mem_we, o_mem_re and o_busy are 0;
- o_mem_addr, o_mem_wdata and o_rdata are 0;
- the tag pipeline is cleared;
- last_winner = NUM_CORES-1, so core 0 has first priority.
REQ-033 Reset mid-operation discards in-flight reads: no o_rvalid is produced for them after reset release.
REQ-034 On the first edge after release, the block arbitrates normally.

Verification
REQ-035 Single read: core 2 reads address 0x0040, DRAM returns 0x5A, RD_LAT=1 -> o_gnt=4'b0100 at edge k; o_mem_re=1 with o_mem_addr=0x0040 in the same cycle; o_rvalid=4'b0100 with o_rdata=0x5A at edge k+2.
REQ-036 All four cores read continuously, ARB_MODE=0 -> grant order 0,1,2,3,0...; one o_mem_re per cycle; o_rvalid order 0,1,2,3.
REQ-037 Same traffic with ARB_MODE=1 and cores 0 and 3 holding requests -> grants alternate 0,3,0,3, because the just-granted mask applies.
REQ-038 Core 1 writes 0xA5 to 0x1234 -> one cycle with o_mem_we=1, o_mem_addr=0x1234, o_mem_wdata=0xA5; no o_rvalid.
REQ-039 RD_LAT=3, read granted at edge k, reset asserted at k+2 -> no o_rvalid ever; o_busy=0 during reset.
REQ-040 NUM_CORES=8, DATA_W=16, only core 7 requesting continuously -> granted every second cycle; o_busy stays high.
